// File: rtl/io_spi_master.sv
// SPI mode-0 master on the DMA IO register bus: CTRL/TXDATA/RXDATA/STATUS at 0xC800..0xC80C.
// Read data is daisy-chained: own data one cycle after a hit, otherwise rdata_in passes through.
`timescale 1ns/1ps
module io_spi_master (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dma_io_we,
   input  logic [15:2] dma_io_wadr,
   input  logic [31:0] dma_io_wdata,
   input  logic [15:2] dma_io_radr,
   input  logic        dma_io_radr_en,
   input  logic [31:0] dma_io_rdata_in,
   output logic [31:0] dma_io_rdata,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_cs_n
);

   localparam int unsigned AW = 14;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 8;
   localparam logic [AW-1:0] ADR_CTRL   = 14'h3200;
   localparam logic [AW-1:0] ADR_TXDATA = 14'h3201;
   localparam logic [AW-1:0] ADR_RXDATA = 14'h3202;
   localparam logic [AW-1:0] ADR_STATUS = 14'h3203;

   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, DONE} state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] clkdiv_q, clkdiv_d;
   logic          cs_level_q, cs_level_d;
   logic [BW-1:0] shift_q, shift_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [BW-1:0] div_cnt_q, div_cnt_d;
   logic          miso_q, miso_d;
   logic          hi_first_q, hi_first_d;
   logic [BW-1:0] rx_q, rx_d;
   logic          rx_valid_q, rx_valid_d;
   logic          overrun_q, overrun_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic          rd_hit_q, rd_hit_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic          wr_ctrl, wr_tx, wr_status, rd_rx, busy, miso_bit;
   logic [BW-1:0] half_load;
   logic          unused_wdata;

   assign wr_ctrl      = dma_io_we && (dma_io_wadr == ADR_CTRL);
   assign wr_tx        = dma_io_we && (dma_io_wadr == ADR_TXDATA);
   assign wr_status    = dma_io_we && (dma_io_wadr == ADR_STATUS);
   assign rd_rx        = dma_io_radr_en && (dma_io_radr == ADR_RXDATA);
   assign busy         = (state_q != IDLE);
   assign unused_wdata = ^dma_io_wdata[DW-1:9];
   // Down-counter reload: half-period is max(clkdiv,1)+1 cycles.
   assign half_load    = (clkdiv_q == '0) ? BW'(1) : clkdiv_q;
   assign miso_bit     = hi_first_q ? spi_miso : miso_q;

   // Next-state, register file and read-port logic
   always_comb begin
      state_d    = state_q;
      clkdiv_d   = clkdiv_q;
      cs_level_d = cs_level_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      div_cnt_d  = div_cnt_q;
      miso_d     = miso_q;
      hi_first_d = hi_first_q;
      rx_d       = rx_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q;
      rd_hit_d   = 1'b0;
      rdata_d    = '0;

      if (wr_ctrl) begin
         clkdiv_d   = dma_io_wdata[7:0];
         cs_level_d = dma_io_wdata[8];
      end
      if (wr_status) overrun_d = 1'b0;
      if (wr_tx && busy) overrun_d = 1'b1;
      if (rd_rx) rx_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (wr_tx) begin
               shift_d   = dma_io_wdata[7:0];
               bit_cnt_d = '0;
               div_cnt_d = half_load;
               state_d   = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (div_cnt_q == '0) begin
               div_cnt_d  = half_load;
               hi_first_d = 1'b1;
               state_d    = SHIFT_HI;
            end else begin
               div_cnt_d = div_cnt_q - BW'(1);
            end
         end
         SHIFT_HI: begin
            // MISO is captured on the first high cycle and shifted in at the falling boundary
            hi_first_d = 1'b0;
            if (hi_first_q) miso_d = spi_miso;
            if (div_cnt_q == '0) begin
               shift_d   = {shift_q[BW-2:0], miso_bit};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = DONE;
               end else begin
                  div_cnt_d = half_load;
                  state_d   = SHIFT_LO;
               end
            end else begin
               div_cnt_d = div_cnt_q - BW'(1);
            end
         end
         DONE: begin
            rx_d       = shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      sclk_d = (state_d == SHIFT_HI);
      mosi_d = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shift_d[BW-1] : 1'b0;

      if (dma_io_radr_en) begin
         case (dma_io_radr)
            ADR_CTRL:   begin rd_hit_d = 1'b1; rdata_d = {23'd0, cs_level_q, clkdiv_q}; end
            ADR_TXDATA: begin rd_hit_d = 1'b1; rdata_d = {24'd0, shift_q}; end
            ADR_RXDATA: begin rd_hit_d = 1'b1; rdata_d = {24'd0, rx_q}; end
            ADR_STATUS: begin rd_hit_d = 1'b1; rdata_d = {29'd0, overrun_q, rx_valid_q, busy}; end
            default:    begin rd_hit_d = 1'b0; rdata_d = '0; end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         clkdiv_q   <= '0;
         cs_level_q <= 1'b1;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         div_cnt_q  <= '0;
         miso_q     <= 1'b0;
         hi_first_q <= 1'b0;
         rx_q       <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         rd_hit_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         clkdiv_q   <= clkdiv_d;
         cs_level_q <= cs_level_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         div_cnt_q  <= div_cnt_d;
         miso_q     <= miso_d;
         hi_first_q <= hi_first_d;
         rx_q       <= rx_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         rd_hit_q   <= rd_hit_d;
         rdata_q    <= rdata_d;
      end
   end

   assign spi_sclk     = sclk_q;
   assign spi_mosi     = mosi_q;
   assign spi_cs_n     = cs_level_q;
   assign dma_io_rdata = rd_hit_q ? rdata_q : dma_io_rdata_in;

endmodule

// File: tb/tb_io_spi_master.sv
// Directed bench for io_spi_master: register access, mode-0 shifting, overrun, DONE/read race, reset abort.
`timescale 1ns/1ps
module tb_io_spi_master;

   localparam logic [13:0] A_CTRL  = 14'h3200;
   localparam logic [13:0] A_TX    = 14'h3201;
   localparam logic [13:0] A_RX    = 14'h3202;
   localparam logic [13:0] A_ST    = 14'h3203;
   localparam logic [13:0] A_OTHER = 14'h1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dma_io_we;
   logic [15:2] dma_io_wadr;
   logic [31:0] dma_io_wdata;
   logic [15:2] dma_io_radr;
   logic        dma_io_radr_en;
   logic [31:0] dma_io_rdata_in;
   logic [31:0] dma_io_rdata;
   logic        spi_sclk, spi_mosi, spi_miso, spi_cs_n;
   logic        loop_en, miso_drv;

   int checks = 0;
   int errors = 0;

   io_spi_master dut (
      .clk(clk), .rst_n(rst_n),
      .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr), .dma_io_wdata(dma_io_wdata),
      .dma_io_radr(dma_io_radr), .dma_io_radr_en(dma_io_radr_en),
      .dma_io_rdata_in(dma_io_rdata_in), .dma_io_rdata(dma_io_rdata),
      .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
   );

   always #5 clk = ~clk;
   assign spi_miso = loop_en ? spi_mosi : miso_drv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [13:0] adr, input logic [31:0] data);
      dma_io_we    = 1'b1;
      dma_io_wadr  = adr;
      dma_io_wdata = data;
      tick();
      dma_io_we    = 1'b0;
   endtask

   task automatic rd(input logic [13:0] adr, output logic [31:0] data);
      dma_io_radr    = adr;
      dma_io_radr_en = 1'b1;
      tick();
      data           = dma_io_rdata;
      dma_io_radr_en = 1'b0;
   endtask

   // Starts a transfer and polls STATUS every cycle; cycle 1 is the one after the TXDATA write.
   task automatic run_xfer(input logic [7:0] txd, input int inject_at, input int ncyc,
                           output int busy_cnt, output int first_busy, output int last_busy,
                           output int rises, output int period, output logic [7:0] bits);
      int   r1, r2;
      logic prev;
      busy_cnt = 0; first_busy = -1; last_busy = -1; rises = 0;
      r1 = -1; r2 = -1; bits = '0; prev = 1'b0;
      wr(A_TX, {24'd0, txd});
      dma_io_radr    = A_ST;
      dma_io_radr_en = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         if (k == inject_at) begin
            dma_io_we    = 1'b1;
            dma_io_wadr  = A_TX;
            dma_io_wdata = 32'h0000_003C;
         end
         tick();
         dma_io_we = 1'b0;
         if (dma_io_rdata[0]) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = k;
            last_busy = k;
         end
         if (spi_sclk && !prev) begin
            rises++;
            bits = {bits[6:0], spi_mosi};
            if (r1 < 0) r1 = k + 1;
            else if (r2 < 0) r2 = k + 1;
         end
         prev = spi_sclk;
      end
      dma_io_radr_en = 1'b0;
      period = r2 - r1;
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  bits;
      int          bc, fb, lb, rs, per;

      rst_n = 1'b0; dma_io_we = 1'b0; dma_io_wadr = '0; dma_io_wdata = '0;
      dma_io_radr = '0; dma_io_radr_en = 1'b0; dma_io_rdata_in = 32'hDEAD_BEEF;
      loop_en = 1'b1; miso_drv = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_sclk", {31'd0, spi_sclk}, 32'd0);
      check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
      check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
      check("rst_rdata_pass", dma_io_rdata, 32'hDEAD_BEEF);
      rst_n = 1'b1;
      tick();

      // Chain pass-through and registered own read
      rd(A_OTHER, d);
      check("miss_pass", d, 32'hDEAD_BEEF);
      rd(A_ST, d);
      check("status_idle", d, 32'h0);
      tick();
      check("pass_after_hit", dma_io_rdata, 32'hDEAD_BEEF);
      rd(A_CTRL, d);
      check("ctrl_reset", d, 32'h0000_0100);

      // 0xA5 loopback at clkdiv=2 with an overrun write at busy cycle 10
      wr(A_CTRL, 32'h0000_0002);
      check("cs_low", {31'd0, spi_cs_n}, 32'd0);
      rd(A_CTRL, d);
      check("ctrl_rb", d, 32'h0000_0002);
      run_xfer(8'hA5, 10, 52, bc, fb, lb, rs, per, bits);
      check("a5_busy_cnt", 32'(bc), 32'd49);
      check("a5_first_busy", 32'(fb), 32'd1);
      check("a5_last_busy", 32'(lb), 32'd49);
      check("a5_rises", 32'(rs), 32'd8);
      check("a5_mosi_bits", {24'd0, bits}, 32'h0000_00A5);
      check("a5_period", 32'(per), 32'd6);
      rd(A_ST, d);
      check("status_overrun", d, 32'h0000_0006);
      wr(A_ST, 32'h0);
      rd(A_ST, d);
      check("status_ovr_clr", d, 32'h0000_0002);
      rd(A_RX, d);
      check("rx_a5", d, 32'h0000_00A5);
      rd(A_ST, d);
      check("status_rx_clr", d, 32'h0);

      // SCLK period versus clkdiv
      wr(A_CTRL, 32'h0000_0000);
      run_xfer(8'h11, 0, 36, bc, fb, lb, rs, per, bits);
      check("div0_period", 32'(per), 32'd4);
      check("div0_busy", 32'(bc), 32'd33);
      wr(A_CTRL, 32'h0000_0001);
      run_xfer(8'h22, 0, 36, bc, fb, lb, rs, per, bits);
      check("div1_period", 32'(per), 32'd4);
      check("div1_bits", {24'd0, bits}, 32'h0000_0022);
      wr(A_CTRL, 32'h0000_0003);
      run_xfer(8'h3C, 0, 68, bc, fb, lb, rs, per, bits);
      check("div3_period", 32'(per), 32'd8);
      check("div3_busy", 32'(bc), 32'd65);

      // RXDATA read coinciding with DONE (clkdiv=0: DONE is busy cycle 33)
      wr(A_CTRL, 32'h0000_0000);
      wr(A_TX, 32'h0000_005A);
      repeat (32) tick();
      rd(A_RX, d);
      check("done_race_old", d, 32'h0000_003C);
      rd(A_ST, d);
      check("done_race_valid", d, 32'h0000_0002);
      rd(A_RX, d);
      check("done_race_new", d, 32'h0000_005A);
      rd(A_ST, d);
      check("done_race_clr", d, 32'h0);

      // CTRL write mid-transfer, then reset during bit 4 (clkdiv=2: bit 4 high is cycles 28..30)
      loop_en = 1'b0; miso_drv = 1'b0;
      wr(A_CTRL, 32'h0000_0002);
      wr(A_TX, 32'h0000_00FF);
      repeat (4) tick();
      wr(A_CTRL, 32'h0000_0102);
      check("cs_while_busy", {31'd0, spi_cs_n}, 32'd1);
      repeat (23) tick();
      check("bit4_sclk", {31'd0, spi_sclk}, 32'd1);
      check("bit4_mosi", {31'd0, spi_mosi}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_sclk", {31'd0, spi_sclk}, 32'd0);
      check("abort_mosi", {31'd0, spi_mosi}, 32'd0);
      check("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      rd(A_ST, d);
      check("abort_status", d, 32'h0);
      rd(A_RX, d);
      check("abort_rx", d, 32'h0);

      // Normal 0x81 transfer after the abort
      loop_en = 1'b1;
      wr(A_CTRL, 32'h0000_0002);
      run_xfer(8'h81, 0, 52, bc, fb, lb, rs, per, bits);
      check("x81_busy", 32'(bc), 32'd49);
      check("x81_bits", {24'd0, bits}, 32'h0000_0081);
      rd(A_ST, d);
      check("x81_status", d, 32'h0000_0002);
      rd(A_RX, d);
      check("x81_rx", d, 32'h0000_0081);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_spi_master.md
IO_SPI_MASTER -- requirements
Module: io_spi_master

Interface
REQ-001 SHALL provide these ports, clock and reset first: clk input 1, system clock; rst_n input 1, asynchronous active-low reset.
REQ-002 SHALL provide IO write bus inputs: dma_io_we 1, write strobe; dma_io_wadr [15:2], word address; dma_io_wdata 32, write data.
REQ-003 SHALL provide IO read bus inputs: dma_io_radr [15:2], word address; dma_io_radr_en 1, read strobe; dma_io_rdata_in 32, read data from the previous chain stage.
REQ-004 SHALL provide dma_io_rdata output 32, read data to the next chain stage.
REQ-005 SHALL provide SPI ports: spi_sclk output 1; spi_mosi output 1; spi_miso input 1; spi_cs_n output 1.
REQ-006 SHALL use one clock, clk, with asynchronous active-low reset rst_n; all flops clear on rst_n low regardless of clk.

Function
REQ-007 SHALL decode four registers by dma_io_wadr/dma_io_radr: CTRL 14'h3200 (byte 0xC800), TXDATA 14'h3201, RXDATA 14'h3202, STATUS 14'h3203; other addresses are ignored.
REQ-008 CTRL SHALL be read/write: [7:0] clkdiv, [8] cs_level driven on spi_cs_n; other bits read 0.
REQ-009 SHALL use a half-period of SCLK equal to max(clkdiv,1)+1 clk cycles.
REQ-010 A TXDATA write in IDLE SHALL load [7:0] into the shift register, set busy, and enter SHIFT_LO on the next cycle.
REQ-011 A TXDATA write while busy (SHIFT_LO, SHIFT_HI, DONE) SHALL be dropped, set overrun, and leave the transfer unaffected.
REQ-012 FSM states SHALL be IDLE, SHIFT_LO, SHIFT_HI, DONE, using SPI mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-013 SHIFT_LO SHALL drive spi_sclk=0 and spi_mosi=shift[7], then go to SHIFT_HI after one half-period.
REQ-014 On entry to SHIFT_HI, spi_sclk SHALL be 1 and spi_miso SHALL be sampled into bit 0 on that first cycle.
REQ-015 At the end of SHIFT_HI, SHALL shift left one bit and increment the 3-bit bit counter; after bit 7, go to DONE, otherwise go to SHIFT_LO.
REQ-016 DONE SHALL last 1 cycle: copy the shift register to RXDATA, set rx_valid, clear busy, and go to IDLE.
REQ-017 Total busy time SHALL be 16*(max(clkdiv,1)+1)+1 cycles, counted from the cycle after the TXDATA write.
REQ-018 STATUS SHALL read [0] busy, [1] rx_valid, [2] overrun; any STATUS write clears overrun.
REQ-019 A RXDATA read SHALL return {24'd0, rxbyte} and clear rx_valid.
REQ-020 When a RXDATA read coincides with DONE, DONE SHALL win: rx_valid stays 1 and the new byte is stored.
REQ-021 A read hit SHALL be registered: with dma_io_radr_en=1 and a hit at cycle N, dma_io_rdata SHALL carry own data at cycle N+1.
REQ-022 In all other cycles, dma_io_rdata SHALL equal dma_io_rdata_in combinationally.
REQ-023 Simultaneous write and read SHALL be legal; a read of a register written in the same cycle returns the pre-write value.
REQ-024 A CTRL write while busy SHALL update cs_level immediately; the new clkdiv takes effect at the next half-period boundary.

Reset
REQ-025 On reset, SHALL clear all state, enter IDLE, and drive spi_sclk=0, spi_mosi=0, spi_cs_n=1 (cs_level=1), clkdiv=0, RXDATA=0, with busy, rx_valid and overrun all 0.
REQ-026 Reset asserted mid-transfer SHALL abort immediately to the REQ-025 state; no partial byte is stored.

Verification
REQ-027 CTRL=0x002, TXDATA=0xA5, spi_miso looped to spi_mosi -> 0xA5 shifted MSB first, 48 busy cycles plus 1 DONE cycle (49 total), then RXDATA=0x000000A5 and STATUS=0x2.
REQ-028 During REQ-027, TXDATA=0x3C written at busy cycle 10 -> transfer continues as 0xA5 and STATUS=0x6; then STATUS write -> STATUS=0x2.
REQ-029 Read of 14'h1000 with dma_io_rdata_in=0xDEADBEEF -> dma_io_rdata=0xDEADBEEF; read of STATUS in IDLE -> 0x00000000 one cycle later.
REQ-030 clkdiv=0 versus clkdiv=1 -> both give an SCLK period of 4 clk cycles; clkdiv=3 gives 8 clk cycles.
REQ-031 RXDATA read in the DONE cycle -> rx_valid remains 1 and the next RXDATA read returns the new byte.
REQ-032 rst_n pulsed low during bit 4 -> outputs at reset values within 0 cycles; a following transfer of 0x81 completes normally.
